// File: rtl/spd_vec_chkr.sv
// Self-check engine for N-channel motor speed outputs: aligns expected speeds to
// the source pipeline latency, compares within a tolerance and reports pass/fail.
module spd_vec_chkr #(
    parameter int NUM_CH      = 4,
    parameter int SPD_W       = 11,
    parameter int LAT         = 1,
    parameter int NUM_VEC     = 2000,
    parameter int TOL         = 0,
    parameter int STOP_ON_ERR = 0,
    parameter int CNT_W       = 16,
    localparam int IDX_W      = (NUM_VEC > 1) ? $clog2(NUM_VEC) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    vec_vld,
    input  logic [NUM_CH*SPD_W-1:0] exp_spd,
    input  logic [NUM_CH*SPD_W-1:0] act_spd,
    output logic                    busy,
    output logic                    done,
    output logic                    pass,
    output logic                    mis,
    output logic [CNT_W-1:0]        err_cnt,
    output logic [IDX_W:0]          chk_cnt,
    output logic [IDX_W-1:0]        first_err_idx,
    output logic [NUM_CH-1:0]       first_err_mask
);

    localparam int VW = NUM_CH * SPD_W;
    localparam logic [IDX_W:0] VEC_TOTAL = (IDX_W+1)'(NUM_VEC);
    localparam logic [IDX_W:0] VEC_LAST  = (IDX_W+1)'(NUM_VEC - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN, ST_DONE} state_t;

    state_t              state_reg, state_next;
    logic [LAT-1:0]      vld_pipe_reg, vld_pipe_next;
    logic [VW-1:0]       exp_pipe_reg  [LAT];
    logic [VW-1:0]       exp_pipe_next [LAT];
    logic [IDX_W:0]      acc_cnt_reg;
    logic [IDX_W:0]      chk_cnt_reg;
    logic [CNT_W-1:0]    err_cnt_reg;
    logic [IDX_W-1:0]    first_idx_reg;
    logic [NUM_CH-1:0]   first_mask_reg;
    logic                mis_reg;

    logic                run_active;
    logic                accept;
    logic                cmp;
    logic                vec_fail;
    logic                stop_hit;
    logic                flush;
    logic [NUM_CH-1:0]   ch_fail;
    logic [VW-1:0]       tap_exp;

    assign run_active = (state_reg == ST_RUN) || (state_reg == ST_DRAIN);
    assign accept     = vec_vld && !start && (state_reg == ST_RUN) && (acc_cnt_reg < VEC_TOTAL);
    assign cmp        = run_active && vld_pipe_reg[LAT-1];
    assign tap_exp    = exp_pipe_reg[LAT-1];
    assign vec_fail   = |ch_fail;
    assign stop_hit   = (STOP_ON_ERR != 0) && cmp && vec_fail;
    // A restart or an early stop empties the alignment line so stale vectors never compare.
    assign flush      = start || stop_hit;

    genvar gi;
    generate
        for (gi = 0; gi < LAT; gi++) begin : g_dly
            if (gi == 0) begin : g_head
                assign vld_pipe_next[gi] = accept && !flush;
                assign exp_pipe_next[gi] = exp_spd;
            end else begin : g_body
                assign vld_pipe_next[gi] = vld_pipe_reg[gi-1] && !flush;
                assign exp_pipe_next[gi] = exp_pipe_reg[gi-1];
            end
        end

        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic [SPD_W:0] act_ext, exp_ext, diff;
            assign act_ext     = {1'b0, act_spd[gi*SPD_W +: SPD_W]};
            assign exp_ext     = {1'b0, tap_exp[gi*SPD_W +: SPD_W]};
            assign diff        = (act_ext >= exp_ext) ? (act_ext - exp_ext) : (exp_ext - act_ext);
            assign ch_fail[gi] = int'(diff) > TOL;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe_reg <= '0;
            for (int i = 0; i < LAT; i++) exp_pipe_reg[i] <= '0;
        end else begin
            vld_pipe_reg <= vld_pipe_next;
            for (int i = 0; i < LAT; i++) exp_pipe_reg[i] <= exp_pipe_next[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_reg <= ST_IDLE;
        else        state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        if (start) begin
            state_next = ST_RUN;
        end else begin
            case (state_reg)
                ST_RUN: begin
                    if (stop_hit)                             state_next = ST_DONE;
                    else if (cmp && chk_cnt_reg == VEC_LAST)  state_next = ST_DONE;
                    else if (accept && acc_cnt_reg == VEC_LAST) state_next = ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (stop_hit || (cmp && chk_cnt_reg == VEC_LAST)) state_next = ST_DONE;
                end
                default: state_next = state_reg;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_cnt_reg    <= '0;
            chk_cnt_reg    <= '0;
            err_cnt_reg    <= '0;
            first_idx_reg  <= '0;
            first_mask_reg <= '0;
            mis_reg        <= 1'b0;
        end else if (start) begin
            acc_cnt_reg    <= '0;
            chk_cnt_reg    <= '0;
            err_cnt_reg    <= '0;
            first_idx_reg  <= '0;
            first_mask_reg <= '0;
            mis_reg        <= 1'b0;
        end else begin
            mis_reg <= cmp && vec_fail;
            if (accept) acc_cnt_reg <= acc_cnt_reg + 1'b1;
            if (cmp) begin
                chk_cnt_reg <= chk_cnt_reg + 1'b1;
                if (vec_fail) begin
                    if (err_cnt_reg != '1) err_cnt_reg <= err_cnt_reg + 1'b1;
                    // A zero error count means this is the run's first failing vector.
                    if (err_cnt_reg == '0) begin
                        first_idx_reg  <= chk_cnt_reg[IDX_W-1:0];
                        first_mask_reg <= ch_fail;
                    end
                end
            end
        end
    end

    assign busy           = run_active;
    assign done           = (state_reg == ST_DONE);
    assign pass           = done && (err_cnt_reg == '0);
    assign mis            = mis_reg;
    assign err_cnt        = err_cnt_reg;
    assign chk_cnt        = chk_cnt_reg;
    assign first_err_idx  = first_idx_reg;
    assign first_err_mask = first_mask_reg;

endmodule

// File: tb/tb_spd_vec_chkr.sv
// Directed bench for spd_vec_chkr: four instances cover the basic, tolerance,
// latency/gap and stop-on-error configurations; reset and restart use the basic one.
module tb_spd_vec_chkr;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_tests++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, expv);
        end else begin
            $display("ok   %s: 0x%0h", tag, obs);
        end
    endtask

    function automatic logic [43:0] all4(input logic [10:0] v);
        return {v, v, v, v};
    endfunction

    // basic: LAT=1, NUM_VEC=4, TOL=0
    logic b_start = 0, b_vld = 0;
    logic [43:0] b_exp = '0, b_act = '0;
    logic b_busy, b_done, b_pass, b_mis;
    logic [15:0] b_err;
    logic [2:0] b_chk;
    logic [1:0] b_idx;
    logic [3:0] b_mask;
    spd_vec_chkr #(.LAT(1), .NUM_VEC(4), .TOL(0), .STOP_ON_ERR(0)) u_base (
        .clk(clk), .rst_n(rst_n), .start(b_start), .vec_vld(b_vld), .exp_spd(b_exp), .act_spd(b_act),
        .busy(b_busy), .done(b_done), .pass(b_pass), .mis(b_mis), .err_cnt(b_err), .chk_cnt(b_chk),
        .first_err_idx(b_idx), .first_err_mask(b_mask));

    // tolerance: LAT=1, NUM_VEC=2, TOL=2
    logic t_start = 0, t_vld = 0;
    logic [43:0] t_exp = '0, t_act = '0;
    logic t_busy, t_done, t_pass, t_mis;
    logic [15:0] t_err;
    logic [1:0] t_chk;
    logic [0:0] t_idx;
    logic [3:0] t_mask;
    spd_vec_chkr #(.LAT(1), .NUM_VEC(2), .TOL(2), .STOP_ON_ERR(0)) u_tol (
        .clk(clk), .rst_n(rst_n), .start(t_start), .vec_vld(t_vld), .exp_spd(t_exp), .act_spd(t_act),
        .busy(t_busy), .done(t_done), .pass(t_pass), .mis(t_mis), .err_cnt(t_err), .chk_cnt(t_chk),
        .first_err_idx(t_idx), .first_err_mask(t_mask));

    // latency: LAT=3, NUM_VEC=3
    logic l_start = 0, l_vld = 0;
    logic [43:0] l_exp = '0, l_act = '0;
    logic l_busy, l_done, l_pass, l_mis;
    logic [15:0] l_err;
    logic [2:0] l_chk;
    logic [1:0] l_idx;
    logic [3:0] l_mask;
    spd_vec_chkr #(.LAT(3), .NUM_VEC(3), .TOL(0), .STOP_ON_ERR(0)) u_lat (
        .clk(clk), .rst_n(rst_n), .start(l_start), .vec_vld(l_vld), .exp_spd(l_exp), .act_spd(l_act),
        .busy(l_busy), .done(l_done), .pass(l_pass), .mis(l_mis), .err_cnt(l_err), .chk_cnt(l_chk),
        .first_err_idx(l_idx), .first_err_mask(l_mask));

    // stop on error: LAT=1, NUM_VEC=4
    logic s_start = 0, s_vld = 0;
    logic [43:0] s_exp = '0, s_act = '0;
    logic s_busy, s_done, s_pass, s_mis;
    logic [15:0] s_err;
    logic [2:0] s_chk;
    logic [1:0] s_idx;
    logic [3:0] s_mask;
    spd_vec_chkr #(.LAT(1), .NUM_VEC(4), .TOL(0), .STOP_ON_ERR(1)) u_stop (
        .clk(clk), .rst_n(rst_n), .start(s_start), .vec_vld(s_vld), .exp_spd(s_exp), .act_spd(s_act),
        .busy(s_busy), .done(s_done), .pass(s_pass), .mis(s_mis), .err_cnt(s_err), .chk_cnt(s_chk),
        .first_err_idx(s_idx), .first_err_mask(s_mask));

    // Drives 4 vectors (all channels = (k+1)*0x100) on the basic instance, act one cycle
    // behind; vector `bad` has its act xored with dlt. Counts mis pulses seen.
    task automatic run_base(input int bad, input logic [43:0] dlt, output int mis_seen);
        mis_seen = 0;
        for (int k = 0; k <= 4; k++) begin
            b_vld = (k < 4);
            b_exp = (k < 4) ? all4(11'((k + 1) * 256)) : '0;
            b_act = (k > 0) ? (all4(11'(k * 256)) ^ ((k - 1 == bad) ? dlt : 44'h0)) : '0;
            @(negedge clk);
            mis_seen += int'(b_mis);
        end
        b_vld = 0;
        b_act = '0;
        repeat (2) begin
            @(negedge clk);
            mis_seen += int'(b_mis);
        end
    endtask

    task automatic pulse_base_start;
        b_start = 1;
        @(negedge clk);
        b_start = 0;
    endtask

    int mis_seen;
    int lat_chk  [8] = '{0, 0, 0, 1, 1, 2, 3, 3};
    bit lat_busy [8] = '{1, 1, 1, 1, 1, 1, 0, 0};
    bit lat_vld  [8] = '{1, 0, 1, 1, 1, 0, 0, 0};

    initial begin
        repeat (2) @(negedge clk);
        check("rst busy", b_busy, 0);
        check("rst done", b_done, 0);
        check("rst pass", b_pass, 0);
        check("rst chk",  b_chk,  0);
        rst_n = 1;
        @(negedge clk);

        // clean run
        pulse_base_start();
        run_base(-1, '0, mis_seen);
        check("clean chk",  b_chk, 4);
        check("clean err",  b_err, 0);
        check("clean done", b_done, 1);
        check("clean pass", b_pass, 1);
        check("clean busy", b_busy, 0);
        check("clean mis",  32'(mis_seen), 0);

        // start in DONE clears, then a run with lft of vector 2 off by one
        pulse_base_start();
        check("restart chk",  b_chk, 0);
        check("restart done", b_done, 0);
        check("restart busy", b_busy, 1);
        run_base(2, 44'h1 << 11, mis_seen);
        check("mis pulses", 32'(mis_seen), 1);
        check("mis err",    b_err, 1);
        check("mis idx",    b_idx, 2);
        check("mis mask",   b_mask, 4'b0010);
        check("mis chk",    b_chk, 4);
        check("mis done",   b_done, 1);
        check("mis pass",   b_pass, 0);

        // tolerance: +2 frnt / -2 rght passes, +3 frnt fails
        t_start = 1; @(negedge clk); t_start = 0;
        t_vld = 1; t_exp = all4(11'h200); t_act = '0;
        @(negedge clk);
        t_exp = all4(11'h200); t_act = {11'h202, 11'h200, 11'h200, 11'h1FE};
        @(negedge clk);
        check("tol2 mis", t_mis, 0);
        t_vld = 0; t_act = {11'h203, 11'h200, 11'h200, 11'h200};
        @(negedge clk);
        check("tol3 mis",  t_mis, 1);
        check("tol3 mask", t_mask, 4'b1000);
        check("tol3 idx",  t_idx, 1);
        check("tol err",   t_err, 1);
        check("tol done",  t_done, 1);

        // LAT=3 with gaps; act is junk except exactly three cycles after each vector
        l_start = 1; @(negedge clk); l_start = 0;
        for (int k = 0; k < 8; k++) begin
            l_vld = lat_vld[k];
            case (k)
                0: l_exp = all4(11'h111);
                2: l_exp = all4(11'h222);
                3: l_exp = all4(11'h333);
                4: l_exp = all4(11'h444);
                default: l_exp = '0;
            endcase
            case (k)
                3: l_act = all4(11'h111);
                5: l_act = all4(11'h222);
                6: l_act = all4(11'h333);
                default: l_act = all4(11'h7FF);
            endcase
            @(negedge clk);
            check($sformatf("lat chk c%0d", k),  l_chk,  lat_chk[k]);
            check($sformatf("lat busy c%0d", k), l_busy, lat_busy[k]);
        end
        l_vld = 0;
        check("lat err",  l_err, 0);
        check("lat pass", l_pass, 1);

        // stop on first error at vector 1 (rght off by one); later traffic ignored
        s_start = 1; @(negedge clk); s_start = 0;
        for (int k = 0; k < 6; k++) begin
            s_vld = 1;
            s_exp = all4(11'((k + 1) * 256));
            if (k >= 3)     s_act = all4(11'h7FF);
            else if (k > 0) s_act = all4(11'(k * 256)) ^ ((k == 2) ? 44'h1 : 44'h0);
            else            s_act = '0;
            @(negedge clk);
            if (k == 2) check("stop mis", s_mis, 1);
        end
        s_vld = 0;
        check("stop done", s_done, 1);
        check("stop chk",  s_chk, 2);
        check("stop err",  s_err, 1);
        check("stop idx",  s_idx, 1);
        check("stop mask", s_mask, 4'b0001);
        check("stop pass", s_pass, 0);
        check("stop mis2", s_mis, 0);

        // mid-run reset after an error, then a clean run
        pulse_base_start();
        b_vld = 1; b_exp = all4(11'h100); b_act = '0;
        @(negedge clk);
        b_exp = all4(11'h200); b_act = all4(11'h100) ^ 44'h1;
        @(negedge clk);
        check("pre-rst err", b_err, 1);
        rst_n = 0;
        #1;
        check("arst busy", b_busy, 0);
        check("arst err",  b_err, 0);
        check("arst chk",  b_chk, 0);
        check("arst mis",  b_mis, 0);
        check("arst mask", b_mask, 0);
        b_vld = 0; b_act = '0;
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        pulse_base_start();
        run_base(-1, '0, mis_seen);
        check("post-rst chk",  b_chk, 4);
        check("post-rst err",  b_err, 0);
        check("post-rst pass", b_pass, 1);
        check("post-rst mis",  32'(mis_seen), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
